// File: rtl/score_display_mux.sv
// Snake-game score tracker with a sequential double-dabble BCD converter and a
// multiplexed, leading-zero-blanked, blinking seven-segment driver.
module score_display_mux #(
  parameter int DIGITS       = 3,
  parameter int SCORE_W      = 10,
  parameter int MAX_SCORE    = 999,
  parameter int SCAN_DIV     = 4,
  parameter int BLINK_FRAMES = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               good_coll,
  input  logic               bad_coll,
  input  logic               show_high,
  output logic [SCORE_W-1:0] score,
  output logic [SCORE_W-1:0] high_score,
  output logic               game_over,
  output logic               busy,
  output logic [DIGITS-1:0]  digit_sel,
  output logic [6:0]         seg
);

  localparam int BCD_W  = 4 * DIGITS;
  localparam int ITER_W = $clog2(SCORE_W + 1);
  localparam int PRE_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int FRM_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [SCORE_W-1:0] MAX_VAL = SCORE_W'(MAX_SCORE);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  logic [SCORE_W-1:0] score_next;
  logic               game_over_next;
  logic [SCORE_W-1:0] disp_value;

  conv_state_t        state, state_next;
  logic [SCORE_W-1:0] latched;
  logic [SCORE_W-1:0] bin_sh;
  logic [BCD_W-1:0]   work_bcd;
  logic [BCD_W-1:0]   dabbled;
  logic [BCD_W-1:0]   bcd;
  logic [ITER_W-1:0]  iter;

  logic [DIGITS-1:0]  shown;
  logic               nonzero_seen;

  logic [PRE_W-1:0]   prescale;
  logic [IDX_W-1:0]   scan_idx;
  logic [FRM_W-1:0]   frame_cnt;
  logic               visible;
  logic               prescale_end;
  logic               idx_end;
  logic               frame_end;

  logic [3:0]         cur_digit;
  logic               cur_shown;
  logic [DIGITS-1:0]  sel_next;

  function automatic logic [6:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 7'b0111111;
      4'd1:    seg_code = 7'b0000110;
      4'd2:    seg_code = 7'b1011011;
      4'd3:    seg_code = 7'b1001111;
      4'd4:    seg_code = 7'b1100110;
      4'd5:    seg_code = 7'b1101101;
      4'd6:    seg_code = 7'b1111101;
      4'd7:    seg_code = 7'b0000111;
      4'd8:    seg_code = 7'b1111111;
      4'd9:    seg_code = 7'b1100111;
      default: seg_code = 7'b0000000;
    endcase
  endfunction

  // bad_coll has priority; a good hit after game over starts a fresh game at 1.
  always_comb begin
    score_next     = score;
    game_over_next = game_over;
    if (bad_coll) begin
      score_next     = '0;
      game_over_next = 1'b1;
    end else if (good_coll) begin
      if (game_over) begin
        score_next     = SCORE_W'(1);
        game_over_next = 1'b0;
      end else begin
        if (score >= MAX_VAL) score_next = MAX_VAL;
        else                  score_next = score + SCORE_W'(1);
        game_over_next = (score_next == MAX_VAL);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      score      <= '0;
      high_score <= '0;
      game_over  <= 1'b0;
    end else begin
      score     <= score_next;
      game_over <= game_over_next;
      if (score_next > high_score) high_score <= score_next;
    end
  end

  assign disp_value = (game_over || show_high) ? high_score : score;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (disp_value != latched) state_next = SHIFT;
      SHIFT:   if (iter == ITER_W'(SCORE_W - 1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  always_comb begin
    dabbled = work_bcd;
    for (int d = 0; d < DIGITS; d++) begin
      if (dabbled[4*d +: 4] >= 4'd5) dabbled[4*d +: 4] = dabbled[4*d +: 4] + 4'd3;
    end
  end

  // The displayed BCD register only changes in DONE, so a partial result is never shown.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latched  <= '0;
      bin_sh   <= '0;
      work_bcd <= '0;
      bcd      <= '0;
      iter     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (disp_value != latched) begin
            latched  <= disp_value;
            bin_sh   <= disp_value;
            work_bcd <= '0;
            iter     <= '0;
          end
        end
        SHIFT: begin
          work_bcd <= BCD_W'({dabbled, bin_sh[SCORE_W-1]});
          bin_sh   <= bin_sh << 1;
          iter     <= iter + ITER_W'(1);
        end
        DONE:    bcd <= work_bcd;
        default: ;
      endcase
    end
  end

  always_comb begin
    shown        = '0;
    nonzero_seen = 1'b0;
    for (int d = DIGITS - 1; d >= 0; d--) begin
      if (bcd[4*d +: 4] != 4'd0) nonzero_seen = 1'b1;
      shown[d] = nonzero_seen || (d == 0);
    end
  end

  assign prescale_end = (prescale == PRE_W'(SCAN_DIV - 1));
  assign idx_end      = (scan_idx == IDX_W'(DIGITS - 1));
  assign frame_end    = prescale_end && idx_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescale <= '0;
      scan_idx <= '0;
    end else if (prescale_end) begin
      prescale <= '0;
      scan_idx <= idx_end ? '0 : scan_idx + IDX_W'(1);
    end else begin
      prescale <= prescale + PRE_W'(1);
    end
  end

  // Blink phase toggles on frame boundaries only while the game is over.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      visible   <= 1'b1;
    end else if (!game_over) begin
      frame_cnt <= '0;
      visible   <= 1'b1;
    end else if (frame_end) begin
      if (frame_cnt == FRM_W'(BLINK_FRAMES - 1)) begin
        frame_cnt <= '0;
        visible   <= ~visible;
      end else begin
        frame_cnt <= frame_cnt + FRM_W'(1);
      end
    end
  end

  always_comb begin
    cur_digit = 4'd0;
    cur_shown = 1'b0;
    sel_next  = '0;
    for (int d = 0; d < DIGITS; d++) begin
      if (scan_idx == IDX_W'(d)) begin
        cur_digit   = bcd[4*d +: 4];
        cur_shown   = shown[d];
        sel_next[d] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digit_sel <= '0;
      seg       <= '0;
    end else begin
      digit_sel <= sel_next;
      seg       <= (visible && cur_shown) ? seg_code(cur_digit) : 7'd0;
    end
  end

endmodule

// File: tb/tb_score_display_mux.sv
// Self-checking bench for score_display_mux: vector table, hand-written corner
// sequences and randomized pulses against a decimal-arithmetic reference model.
module tb_score_display_mux;

  localparam int DIGITS       = 3;
  localparam int SCORE_W      = 10;
  localparam int MAX_SCORE    = 999;
  localparam int SCAN_DIV     = 4;
  localparam int BLINK_FRAMES = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               good_coll;
  logic               bad_coll;
  logic               show_high;
  logic [SCORE_W-1:0] score;
  logic [SCORE_W-1:0] high_score;
  logic               game_over;
  logic               busy;
  logic [DIGITS-1:0]  digit_sel;
  logic [6:0]         seg;

  int checks = 0;
  int errors = 0;

  int m_score;
  int m_high;
  bit m_go;

  typedef struct {
    bit good;
    bit bad;
    int e_score;
    int e_high;
    bit e_go;
    bit disp;
  } vec_t;

  vec_t vecs[$];

  score_display_mux #(
    .DIGITS(DIGITS), .SCORE_W(SCORE_W), .MAX_SCORE(MAX_SCORE),
    .SCAN_DIV(SCAN_DIV), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst(rst), .good_coll(good_coll), .bad_coll(bad_coll),
    .show_high(show_high), .score(score), .high_score(high_score),
    .game_over(game_over), .busy(busy), .digit_sel(digit_sel), .seg(seg)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] segOf(input int d);
    case (d)
      0: segOf = 7'b0111111;
      1: segOf = 7'b0000110;
      2: segOf = 7'b1011011;
      3: segOf = 7'b1001111;
      4: segOf = 7'b1100110;
      5: segOf = 7'b1101101;
      6: segOf = 7'b1111101;
      7: segOf = 7'b0000111;
      8: segOf = 7'b1111111;
      9: segOf = 7'b1100111;
      default: segOf = 7'b0000000;
    endcase
  endfunction

  function automatic int pow10(input int n);
    int p = 1;
    for (int k = 0; k < n; k++) p = p * 10;
    return p;
  endfunction

  function automatic vec_t mk(input bit g, input bit b, input int s, input int h,
                              input bit go, input bit d);
    vec_t v;
    v.good = g; v.bad = b; v.e_score = s; v.e_high = h; v.e_go = go; v.disp = d;
    return v;
  endfunction

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string name);
    checkOutput({name, " score"}, int'(score), m_score);
    checkOutput({name, " high_score"}, int'(high_score), m_high);
    checkOutput({name, " game_over"}, int'(game_over), int'(m_go));
  endtask

  task automatic applyStimulus(input bit g, input bit b);
    @(negedge clk);
    good_coll = g;
    bad_coll  = b;
    @(posedge clk);
    #1;
    good_coll = 1'b0;
    bad_coll  = 1'b0;
    if (b) begin
      m_score = 0;
      m_go    = 1'b1;
    end else if (g) begin
      if (m_go) begin
        m_score = 1;
        m_go    = 1'b0;
      end else begin
        m_score = m_score + 1;
        if (m_score >= MAX_SCORE) begin
          m_score = MAX_SCORE;
          m_go    = 1'b1;
        end
      end
    end
    if (m_score > m_high) m_high = m_score;
  endtask

  task automatic doReset();
    @(negedge clk);
    rst       = 1'b1;
    good_coll = 1'b0;
    bad_coll  = 1'b0;
    #2;
    checkOutput("rst score", int'(score), 0);
    checkOutput("rst high_score", int'(high_score), 0);
    checkOutput("rst game_over", int'(game_over), 0);
    checkOutput("rst busy", int'(busy), 0);
    checkOutput("rst digit_sel", int'(digit_sel), 0);
    checkOutput("rst seg", int'(seg), 0);
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    m_score = 0;
    m_high  = 0;
    m_go    = 1'b0;
    step();
    checkOutput("post-rst digit_sel", int'(digit_sel), 1);
    checkOutput("post-rst seg", int'(seg), int'(7'b0111111));
  endtask

  // Watches a full blink period and counts, per digit, cycles showing the expected glyph.
  task automatic checkDisplay(input string name);
    int val;
    bit blink;
    int vis[DIGITS];
    int bad[DIGITS];
    int onehot_err;
    int idx;
    logic [6:0] expv;
    val   = (m_go || show_high) ? m_high : m_score;
    blink = m_go;
    onehot_err = 0;
    for (int i = 0; i < DIGITS; i++) begin
      vis[i] = 0;
      bad[i] = 0;
    end
    repeat (2 * (SCORE_W + 2) + 6) step();
    for (int c = 0; c < 2 * BLINK_FRAMES * DIGITS * SCAN_DIV; c++) begin
      step();
      idx = -1;
      for (int i = 0; i < DIGITS; i++) if (int'(digit_sel) == (1 << i)) idx = i;
      if (idx < 0) onehot_err++;
      else begin
        if (idx == 0 || val >= pow10(idx)) expv = segOf((val / pow10(idx)) % 10);
        else expv = 7'd0;
        if (seg == expv && expv != 7'd0) vis[idx]++;
        else if (seg != 7'd0) bad[idx]++;
      end
    end
    checkOutput($sformatf("%s onehot errors", name), onehot_err, 0);
    for (int i = 0; i < DIGITS; i++) begin
      checkOutput($sformatf("%s d%0d wrong glyph", name, i), bad[i], 0);
      if (i == 0 || val >= pow10(i))
        checkOutput($sformatf("%s d%0d lit cycles", name, i), vis[i],
                    blink ? BLINK_FRAMES * SCAN_DIV : 2 * BLINK_FRAMES * SCAN_DIV);
      else
        checkOutput($sformatf("%s d%0d lit cycles", name, i), vis[i], 0);
    end
  endtask

  task automatic checkScan();
    logic [DIGITS-1:0] prev;
    bit found = 1'b0;
    for (int k = 0; k < 4 * DIGITS * SCAN_DIV && !found; k++) begin
      prev = digit_sel;
      step();
      if (prev == 3'b100 && digit_sel == 3'b001) found = 1'b1;
    end
    checkOutput("scan sync", int'(found), 1);
    if (found) begin
      for (int c = 0; c < 2 * DIGITS * SCAN_DIV; c++) begin
        checkOutput($sformatf("scan cycle %0d", c), int'(digit_sel), 1 << ((c / SCAN_DIV) % DIGITS));
        step();
      end
    end
  endtask

  initial begin
    good_coll = 1'b0;
    bad_coll  = 1'b0;
    show_high = 1'b0;
    rst       = 1'b0;
    #1 rst    = 1'b1;
    m_score = 0;
    m_high  = 0;
    m_go    = 1'b0;

    vecs.push_back(mk(1, 0, 1, 1, 0, 0));
    vecs.push_back(mk(1, 0, 2, 2, 0, 0));
    vecs.push_back(mk(1, 0, 3, 3, 0, 0));
    vecs.push_back(mk(1, 0, 4, 4, 0, 0));
    vecs.push_back(mk(1, 0, 5, 5, 0, 0));
    vecs.push_back(mk(1, 1, 0, 5, 1, 0));
    vecs.push_back(mk(0, 1, 0, 5, 1, 0));
    vecs.push_back(mk(1, 0, 1, 5, 0, 0));
    vecs.push_back(mk(1, 0, 2, 5, 0, 0));
    vecs.push_back(mk(0, 0, 2, 5, 0, 0));
    vecs.push_back(mk(1, 1, 0, 5, 1, 0));
    vecs.push_back(mk(1, 0, 1, 5, 0, 0));
    vecs.push_back(mk(1, 0, 2, 5, 0, 0));
    vecs.push_back(mk(1, 0, 3, 5, 0, 0));
    vecs.push_back(mk(1, 0, 4, 5, 0, 0));
    vecs.push_back(mk(1, 0, 5, 5, 0, 0));
    vecs.push_back(mk(1, 0, 6, 6, 0, 0));
    vecs.push_back(mk(1, 0, 7, 7, 0, 0));
    vecs.push_back(mk(0, 1, 0, 7, 1, 1));
    vecs.push_back(mk(1, 0, 1, 7, 0, 0));
    vecs.push_back(mk(1, 0, 2, 7, 0, 0));
    vecs.push_back(mk(1, 0, 3, 7, 0, 1));

    doReset();

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].good, vecs[n].bad);
      checkOutput($sformatf("vec%0d score", n), int'(score), vecs[n].e_score);
      checkOutput($sformatf("vec%0d high_score", n), int'(high_score), vecs[n].e_high);
      checkOutput($sformatf("vec%0d game_over", n), int'(game_over), int'(vecs[n].e_go));
      if (vecs[n].disp) checkDisplay($sformatf("vec%0d display", n));
    end

    show_high = 1'b1;
    checkDisplay("show_high on");
    show_high = 1'b0;
    checkDisplay("show_high off");

    doReset();
    repeat (12) applyStimulus(1'b1, 1'b0);
    checkOutput("twelve score", int'(score), 12);
    checkDisplay("twelve");
    checkScan();

    doReset();
    repeat (MAX_SCORE) applyStimulus(1'b1, 1'b0);
    checkOutput("sat score", int'(score), 999);
    checkOutput("sat high_score", int'(high_score), 999);
    checkOutput("sat game_over", int'(game_over), 1);
    checkDisplay("sat display");
    applyStimulus(1'b1, 1'b0);
    checkOutput("sat restart score", int'(score), 1);
    checkOutput("sat restart game_over", int'(game_over), 0);

    doReset();
    for (int n = 0; n < 400; n++) begin
      int r;
      r = $urandom_range(0, 99);
      show_high = ($urandom_range(0, 7) == 0);
      applyStimulus(r < 40, r >= 97);
      checkState($sformatf("rand%0d", n));
    end
    show_high = 1'b0;
    checkDisplay("rand display");

    if (m_go) applyStimulus(1'b1, 1'b0);
    applyStimulus(1'b1, 1'b0);
    begin
      bit seen = 1'b0;
      for (int k = 0; k < 5 && !seen; k++) begin
        if (busy) seen = 1'b1;
        else step();
      end
      checkOutput("midconv busy seen", int'(seen), 1);
    end
    #2 rst = 1'b1;
    #1;
    checkOutput("midconv rst busy", int'(busy), 0);
    checkOutput("midconv rst score", int'(score), 0);
    checkOutput("midconv rst seg", int'(seg), 0);
    checkOutput("midconv rst digit_sel", int'(digit_sel), 0);
    repeat (2) @(negedge clk);
    rst     = 1'b0;
    m_score = 0;
    m_high  = 0;
    m_go    = 1'b0;
    step();
    checkOutput("midconv release digit_sel", int'(digit_sel), 1);
    checkOutput("midconv release seg", int'(seg), int'(7'b0111111));
    checkOutput("midconv release busy", int'(busy), 0);
    checkDisplay("midconv display");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
